spectrum_accumulator: RTL and testbench
=======================================

# spectrum_accumulator

Parametrised multi-pulse power-spectrum accumulator for the lidar processing chain. It sits between the FFT/power-spectrum stage and the upload path. It sums N consecutive pulses of BINS×GATES spectrum words into internal dual-port RAM using saturating arithmetic. It then streams the accumulated frame out over a valid/ready interface. Compared with the previous buffer, it adds a programmable pulse count, generic geometry, overflow detection, backpressure, abort and frame bookkeeping.

## Interface
- DIN_W, 50, width of input power-spectrum word
- ACC_W, 64, accumulator/output word width; ACC_W ≥ DIN_W
- BINS, 512, spectral bins per range gate
- GATES, 16, range gates per pulse; BINS×GATES ≥ 4
- NPLS_W, 16, width of pulse-count input
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new accumulation (ignored unless IDLE)
- abort  in  1  synchronous; returns to IDLE from any state, no done
- num_pulses  in  NPLS_W  pulses to accumulate, sampled on start; 0 treated as 1
- din  in  DIN_W  spectrum word, unsigned
- din_valid  in  1  din qualifier; one word per cycle max, gaps allowed
- dout  out  ACC_W  accumulated word
- dout_valid  out  1  dout qualifier
- dout_ready  in  1  downstream accept
- dout_last  out  1  high with final word (index BINS×GATES−1)
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after last output beat accepted
- overflow  out  1  sticky; any add saturated; cleared on accepted start
- pulse_cnt  out  NPLS_W  pulses completed in current accumulation

## Operation
- States: IDLE, ACCUM, FLUSH, READOUT.
- IDLE: din_valid ignored. start → ACCUM; latch num_pulses; clear addr, pulse_cnt and overflow.
- ACCUM, per din_valid:
  - Read RAM[addr]; addr increments, wrapping at BINS×GATES−1.
  - First pulse (pulse_cnt==0): write zero-extended din; no prior clear of RAM needed.
  - Later pulses: write sat(RAM[addr]+din). If the true sum ≥ 2^ACC_W, write all-ones and set overflow.
  - On wrap, pulse_cnt increments. When pulse_cnt reaches latched N → FLUSH.
- FLUSH: wait until RMW pipeline empty (2 cycles), then → READOUT. din_valid is ignored in FLUSH and READOUT.
- READOUT: read addresses 0..BINS×GATES−1 in order to dout. Hold dout/dout_valid/dout_last stable while dout_valid & !dout_ready. Use a skid/prefetch register so RAM read latency never drops throughput. After the last beat is accepted → IDLE, done=1 for one cycle.
- abort: any state → IDLE next cycle. dout_valid drops and any pending write is discarded. overflow and pulse_cnt are held. done is not pulsed.
- start while busy: ignored, no effect on any state.
- start and abort in the same cycle in IDLE: abort wins and the block stays IDLE.
- Reset: all control state cleared; RAM contents undefined and never read before being overwritten.

## Timing
- Reset values: dout=0, dout_valid=0, dout_last=0, busy=0, done=0, overflow=0, pulse_cnt=0.
- busy rises the cycle after start.
- RMW latency is 2. din_valid at cycle t: RAM read issued t, sum registered t+1, written t+2.
- Back-to-back din_valid is supported with no hazard; consecutive addresses differ and depth ≥ 4.
- pulse_cnt updates the cycle after the write of a pulse's final word.
- Last sample of final pulse at t: FLUSH at t+1, READOUT at t+3.
- First dout_valid no later than 2 cycles after entering READOUT.
- With dout_ready held high: one word per cycle, BINS×GATES consecutive beats.
- done is asserted the cycle after the final handshake; busy falls in the same cycle.
- overflow is set the cycle the saturated value is written.

## Test plan
Scenarios 1–4 use DIN_W=6, ACC_W=8, BINS=4, GATES=2.
- N=1, din=k for k=0..7 back-to-back, dout_ready=1 → dout 0..7, dout_last on 7, done once, overflow=0.
- N=3, din=10 every word, random din_valid gaps → every dout=30, pulse_cnt=3 at READOUT.
- N=5, din=63 every word → pulses 1–4 give 252, pulse 5 saturates: every dout=255, overflow=1; next start clears overflow.
- N=2, dout_ready toggled 1/0 randomly during READOUT → all 8 words delivered exactly once, in order, dout stable while stalled.
- Default params, abort mid-ACCUM then start N=1 → output equals second-run input only. rst_n low during READOUT → all outputs at reset values immediately.
- num_pulses=0; start pulsed while busy → accumulation behaves as N=1; second start has no effect.

Source files
------------

// File: rtl/spectrum_accumulator.sv
// Multi-pulse power-spectrum accumulator: saturating read-modify-write sums of N pulses
// into on-chip RAM, then streams the frame out over valid/ready with a skid buffer.
//
// state   | meaning
// IDLE    | waiting for start, din ignored
// ACCUM   | summing incoming pulses into RAM
// FLUSH   | draining the two-stage RMW pipeline
// READOUT | streaming RAM words 0..DEPTH-1 to dout
module spectrum_accumulator #(
  parameter int DIN_W  = 50,
  parameter int ACC_W  = 64,
  parameter int BINS   = 512,
  parameter int GATES  = 16,
  parameter int NPLS_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [NPLS_W-1:0] num_pulses,
  input  logic [DIN_W-1:0]  din,
  input  logic              din_valid,
  output logic [ACC_W-1:0]  dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_last,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [NPLS_W-1:0] pulse_cnt
);
  localparam int DEPTH = BINS * GATES;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_READOUT} state_t;

  state_t             state;
  logic [NPLS_W-1:0]  n_lat, in_pulse;
  logic [AW-1:0]      acc_addr, rd_addr;
  logic               flush_cnt, rd_all, rd_pend, pend_last;
  logic               s1_valid, s1_first, s2_valid, s2_sat;
  logic [AW-1:0]      s1_addr, s2_addr;
  logic [DIN_W-1:0]   s1_din;
  logic [ACC_W-1:0]   s2_data, ram_q, sk_d;
  logic               sk_v, sk_last;
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   ram [DEPTH];
  logic               acc_in, acc_wrap, pop, held, issue, ram_we;
  logic [AW-1:0]      ram_raddr;

  assign acc_in    = (state == S_ACCUM) && din_valid;
  assign acc_wrap  = acc_in && (acc_addr == LAST);
  assign pop       = dout_valid && dout_ready;
  assign held      = dout_valid && !dout_ready;
  // Only fetch when the output + skid registers can absorb the word in flight.
  assign issue     = (state == S_READOUT) && !rd_all &&
                     (({1'b0, held} + {1'b0, sk_v} + {1'b0, rd_pend}) <= 2'd1);
  assign ram_raddr = (state == S_READOUT) ? rd_addr : acc_addr;
  assign ram_we    = s2_valid && !abort;
  assign sum_ext   = {1'b0, ram_q} + (ACC_W+1)'(s1_din);

  always_ff @(posedge clk) begin
    if (ram_we) ram[s2_addr] <= s2_data;
    ram_q <= ram[ram_raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_addr  <= '0;
      s1_din   <= '0;
      s2_valid <= 1'b0;
      s2_sat   <= 1'b0;
      s2_addr  <= '0;
      s2_data  <= '0;
    end else begin
      s1_valid <= acc_in && !abort;
      s1_first <= (in_pulse == '0);
      s1_addr  <= acc_addr;
      s1_din   <= din;
      s2_valid <= s1_valid && !abort;
      s2_addr  <= s1_addr;
      // The first pulse overwrites, so RAM never needs clearing between frames.
      if (s1_first) begin
        s2_data <= ACC_W'(s1_din);
        s2_sat  <= 1'b0;
      end else if (sum_ext[ACC_W]) begin
        s2_data <= '1;
        s2_sat  <= 1'b1;
      end else begin
        s2_data <= sum_ext[ACC_W-1:0];
        s2_sat  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      n_lat      <= '0;
      in_pulse   <= '0;
      acc_addr   <= '0;
      flush_cnt  <= 1'b0;
      rd_addr    <= '0;
      rd_all     <= 1'b0;
      rd_pend    <= 1'b0;
      pend_last  <= 1'b0;
      sk_v       <= 1'b0;
      sk_d       <= '0;
      sk_last    <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      pulse_cnt  <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
        sk_v       <= 1'b0;
        rd_pend    <= 1'b0;
      end else begin
        if (ram_we) begin
          if (s2_addr == LAST) pulse_cnt <= pulse_cnt + NPLS_W'(1);
          if (s2_sat) overflow <= 1'b1;
        end
        case (state)
          S_IDLE: begin
            if (start) begin
              state     <= S_ACCUM;
              busy      <= 1'b1;
              n_lat     <= (num_pulses == '0) ? NPLS_W'(1) : num_pulses;
              in_pulse  <= '0;
              acc_addr  <= '0;
              pulse_cnt <= '0;
              overflow  <= 1'b0;
            end
          end
          S_ACCUM: begin
            if (acc_in) acc_addr <= acc_wrap ? '0 : acc_addr + AW'(1);
            if (acc_wrap) begin
              in_pulse <= in_pulse + NPLS_W'(1);
              if ((in_pulse + NPLS_W'(1)) == n_lat) begin
                state     <= S_FLUSH;
                flush_cnt <= 1'b0;
              end
            end
          end
          S_FLUSH: begin
            flush_cnt <= 1'b1;
            if (flush_cnt) begin
              state   <= S_READOUT;
              rd_addr <= '0;
              rd_all  <= 1'b0;
              rd_pend <= 1'b0;
              sk_v    <= 1'b0;
            end
          end
          S_READOUT: begin
            rd_pend   <= issue;
            pend_last <= issue && (rd_addr == LAST);
            if (issue) begin
              rd_addr <= rd_addr + AW'(1);
              if (rd_addr == LAST) rd_all <= 1'b1;
            end
            if (!dout_valid || pop) begin
              if (sk_v) begin
                dout       <= sk_d;
                dout_valid <= 1'b1;
                dout_last  <= sk_last;
                sk_v       <= rd_pend;
                sk_d       <= ram_q;
                sk_last    <= pend_last;
              end else if (rd_pend) begin
                dout       <= ram_q;
                dout_valid <= 1'b1;
                dout_last  <= pend_last;
              end else begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
              end
            end else if (rd_pend) begin
              sk_v    <= 1'b1;
              sk_d    <= ram_q;
              sk_last <= pend_last;
            end
            if (pop && dout_last) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spectrum_accumulator.sv
// Randomized scoreboard bench for spectrum_accumulator on an 8-word (4x2) geometry.
module tb_spectrum_accumulator;
  localparam int DIN_W = 6, ACC_W = 8, BINS = 4, GATES = 2, NPLS_W = 16;
  localparam int DEPTH = BINS * GATES;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              start = 1'b0, abort = 1'b0, din_valid = 1'b0, dout_ready = 1'b1;
  logic [NPLS_W-1:0] num_pulses = '0;
  logic [DIN_W-1:0]  din = '0;
  logic [ACC_W-1:0]  dout;
  logic              dout_valid, dout_last, busy, done, overflow;
  logic [NPLS_W-1:0] pulse_cnt;

  spectrum_accumulator #(.DIN_W(DIN_W), .ACC_W(ACC_W), .BINS(BINS), .GATES(GATES),
                         .NPLS_W(NPLS_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_pulses(num_pulses),
    .din(din), .din_valid(din_valid), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .busy(busy), .done(done),
    .overflow(overflow), .pulse_cnt(pulse_cnt));

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int done_cnt = 0, beat_idx = 0, cyc = 0, first_cyc = 0, last_cyc = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_dout;
  logic       prev_last;
  bit         rnd_ready = 1'b0;
  logic       ready_force = 1'b1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_force;
  end

  // Monitor: pops the expected frame on every accepted beat, checks stall stability.
  always @(negedge clk) begin
    if (!rst_n) prev_stall = 1'b0;
    else begin
      if (done) done_cnt++;
      if (prev_stall)
        chk("stall_hold", {dout_valid, dout_last, dout}, {1'b1, prev_last, prev_dout});
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) chk("unexpected_beat", exp_q.size(), 1);
        else begin
          mon_e = exp_q.pop_front();
          chk("beat_data", dout, mon_e[7:0]);
          chk("beat_last", dout_last, mon_e[8]);
          if (beat_idx == 0) first_cyc = cyc;
          if (mon_e[8]) last_cyc = cyc;
          beat_idx++;
        end
      end
      prev_stall = dout_valid && !dout_ready && !abort;
      prev_dout  = dout;
      prev_last  = dout_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_pulses = NPLS_W'(n);
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ovf_cleared", overflow, 0);
    chk("pcnt_cleared", pulse_cnt, 0);
  endtask

  task automatic feed_frame(input int mode);
    for (int i = 0; i < DEPTH; i++) begin
      din = (mode == 0) ? DIN_W'(i) : DIN_W'($urandom);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    for (n = 0; n < 20; n++) begin
      if (dout_valid) break;
      @(negedge clk);
    end
    chk("valid_seen", n < 20, 1);
  endtask

  // mode: 0 = index ramp, 1 = constant 10, 2 = constant 63, 3 = random
  task automatic run_frame(input int n_req, input int mode, input bit gaps, input bit rr,
                           input bit extra_start);
    int n_eff, d, d0, n;
    int acc[DEPTH];
    bit ovf;
    n_eff = (n_req == 0) ? 1 : n_req;
    ovf = 1'b0;
    d0 = done_cnt;
    rnd_ready = 1'b0;
    ready_force = 1'b1;
    beat_idx = 0;
    do_start(n_req);
    for (int p = 0; p < n_eff; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            din_valid = 1'b0;
            din = DIN_W'($urandom);
            tick();
          end
        end
        case (mode)
          0: d = i;
          1: d = 10;
          2: d = 63;
          default: d = $urandom_range(0, 63);
        endcase
        if (p == 0) acc[i] = d;
        else begin
          acc[i] += d;
          if (acc[i] > 255) begin
            acc[i] = 255;
            ovf = 1'b1;
          end
        end
        din = DIN_W'(d);
        din_valid = 1'b1;
        if (extra_start && p == 0 && i == 3) begin
          start = 1'b1;
          num_pulses = NPLS_W'(3);
        end else start = 1'b0;
        tick();
      end
    end
    din_valid = 1'b0;
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({(i == DEPTH - 1), 8'(acc[i])});
    rnd_ready = rr;
    wait_valid(n);
    chk("pcnt_readout", pulse_cnt, n_eff);
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_seen", n < 200, 1);
    chk("busy_fall", busy, 0);
    tick();
    rnd_ready = 1'b0;
    chk("done_once", done_cnt - d0, 1);
    chk("overflow", overflow, ovf);
    chk("queue_empty", exp_q.size(), 0);
    if (!rr) chk("throughput", last_cyc - first_cyc, DEPTH - 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_last", dout_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pcnt", pulse_cnt, 0);
    rst_n = 1'b1;
    tick();

    run_frame(1, 0, 1'b0, 1'b0, 1'b0);
    run_frame(3, 1, 1'b1, 1'b0, 1'b0);
    run_frame(5, 2, 1'b0, 1'b0, 1'b0);
    run_frame(4, 2, 1'b0, 1'b0, 1'b0);
    run_frame(2, 3, 1'b1, 1'b1, 1'b0);

    // start and abort together in IDLE: abort wins
    start = 1'b1;
    abort = 1'b1;
    num_pulses = NPLS_W'(1);
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", busy, 0);
    tick();
    chk("start_abort_idle2", busy, 0);

    // abort mid-ACCUM after one full pulse has been written
    d0 = done_cnt;
    do_start(2);
    for (int i = 0; i < DEPTH + 2; i++) begin
      din = DIN_W'(63);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", dout_valid, 0);
    chk("abort_pcnt_held", pulse_cnt, 1);
    repeat (5) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    run_frame(1, 3, 1'b0, 1'b0, 1'b0);

    // abort while stalled in READOUT
    d0 = done_cnt;
    ready_force = 1'b0;
    do_start(1);
    feed_frame(3);
    wait_valid(n);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_ro_valid", dout_valid, 0);
    chk("abort_ro_busy", busy, 0);
    tick();
    chk("abort_ro_no_done", done_cnt - d0, 0);
    ready_force = 1'b1;
    tick();

    // reset while in READOUT: outputs clear without waiting for a clock
    ready_force = 1'b0;
    do_start(1);
    feed_frame(0);
    wait_valid(n);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ro_dout", dout, 0);
    chk("rst_ro_valid", dout_valid, 0);
    chk("rst_ro_last", dout_last, 0);
    chk("rst_ro_busy", busy, 0);
    chk("rst_ro_done", done, 0);
    chk("rst_ro_ovf", overflow, 0);
    chk("rst_ro_pcnt", pulse_cnt, 0);
    exp_q.delete();
    ready_force = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // num_pulses=0 acts as 1; a start while busy is ignored
    run_frame(0, 3, 1'b0, 1'b0, 1'b1);

    for (int k = 0; k < 6; k++)
      run_frame($urandom_range(0, 6), 3, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
